// File: rtl/ncpu32k_burst_arbiter.sv
// ncpu32k_burst_arbiter: grants one of NR requesters a shared valid/ready channel for a whole burst.
// Grant is registered (1-cycle arbitration latency); payload/ready steering is combinational from it.
// Optional macro NCPU_BURST_ARB_RR_EN replaces fixed priority (bit 0 highest) with round-robin.

module ncpu32k_priority_onehot #(
  parameter int DW            = 4,
  parameter bit POLARITY_DIN  = 1'b1,
  parameter bit POLARITY_DOUT = 1'b1
) (
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);
  logic [DW-1:0] act;
  logic [DW-1:0] pick;

  // Isolate the lowest-index active bit (bit 0 wins).
  always_comb begin
    act  = POLARITY_DIN ? din : ~din;
    pick = act & (~act + DW'(1));
    dout = POLARITY_DOUT ? pick : ~pick;
  end
endmodule

module ncpu32k_burst_arbiter #(
  parameter int NR  = 4,
  parameter int DW  = 32,
  parameter int IDW = $clog2(NR)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NR-1:0]    req_valid,
  input  logic [NR*DW-1:0] req_data,
  input  logic [NR-1:0]    req_last,
  output logic [NR-1:0]    req_ready,
  output logic             out_valid,
  output logic [DW-1:0]    out_data,
  output logic             out_last,
  output logic [IDW-1:0]   out_id,
  input  logic             out_ready,
  output logic [NR-1:0]    grant
);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  logic [NR-1:0] grant_r;
  logic [NR-1:0] pick;
  logic [0:0]    state;
  logic          burst_end;

  // The state is implied by the grant register: any set bit means a burst owns the channel.
  assign state     = (|grant_r) ? S_BUSY : S_IDLE;
  assign grant     = grant_r;
  assign burst_end = (state == S_BUSY) & out_valid & out_ready & out_last;

`ifdef NCPU_BURST_ARB_RR_EN
  logic [IDW-1:0] rr_ptr;
  logic [NR-1:0]  masked;
  logic [NR-1:0]  pick_masked;
  logic [NR-1:0]  pick_unmasked;

  // Only requesters above the last winner compete first, so everyone gets a turn.
  always_comb begin
    masked = '0;
    for (int i = 0; i < NR; i++) begin
      if (i > int'(rr_ptr)) masked[i] = req_valid[i];
    end
  end

  ncpu32k_priority_onehot #(.DW(NR), .POLARITY_DIN(1'b1), .POLARITY_DOUT(1'b1)) u_pick_masked (
    .din  (masked),
    .dout (pick_masked)
  );

  ncpu32k_priority_onehot #(.DW(NR), .POLARITY_DIN(1'b1), .POLARITY_DOUT(1'b1)) u_pick_unmasked (
    .din  (req_valid),
    .dout (pick_unmasked)
  );

  assign pick = (|masked) ? pick_masked : pick_unmasked;

  // Remember the winner of each finished burst as the round-robin origin.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            rr_ptr <= '0;
    else if (burst_end) rr_ptr <= out_id;
  end
`else
  ncpu32k_priority_onehot #(.DW(NR), .POLARITY_DIN(1'b1), .POLARITY_DOUT(1'b1)) u_pick (
    .din  (req_valid),
    .dout (pick)
  );
`endif

  // Grant register: load the pick only from IDLE, clear on the beat carrying last.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   grant_r <= '0;
    else if (state == S_IDLE)  grant_r <= pick;
    else if (burst_end)        grant_r <= '0;
  end

  // Steer the winner's beat downstream and the downstream ready back to the winner only.
  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    out_id    = '0;
    for (int i = 0; i < NR; i++) begin
      if (grant_r[i]) begin
        out_valid = req_valid[i];
        out_data  = req_data[i*DW +: DW];
        out_last  = req_last[i];
        out_id    = IDW'(i);
      end
    end
    req_ready = grant_r & {NR{out_ready}};
  end
endmodule

// File: tb/tb_ncpu32k_burst_arbiter.sv
// Directed bench for ncpu32k_burst_arbiter (NR=4, DW=32, default fixed-priority build).
// Requester behaviour model drives bursts; an index-based reference model is compared every cycle.
// Literal expectations from hand-worked timelines pin the reference model.

module tb_ncpu32k_burst_arbiter;
  localparam int NR = 4;
  localparam int DW = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NR-1:0]    req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    req_last;
  logic [NR-1:0]    req_ready;
  logic             out_valid;
  logic [DW-1:0]    out_data;
  logic             out_last;
  logic [1:0]       out_id;
  logic             out_ready = 1'b1;
  logic [NR-1:0]    grant;

  int tests = 0;
  int fails = 0;

  // Requester state, written only by the stimulus process.
  bit          act   [NR];
  bit          hold  [NR];
  bit          autor [NR];
  int          cnt   [NR];
  int          len   [NR];
  logic [31:0] base  [NR];

  // Handshakes observed mid-cycle, consumed at the following edge.
  logic [NR-1:0] fire      = '0;
  logic [NR-1:0] fire_last = '0;

  // Reference model: index of granted requester, -1 when idle.
  int m_g = -1;

  ncpu32k_burst_arbiter #(.NR(NR), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_id    (out_id),
    .out_ready (out_ready),
    .grant     (grant)
  );

  always #5 clk = ~clk;

  always_comb begin
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    for (int i = 0; i < NR; i++) begin
      req_valid[i]          = act[i] && !hold[i];
      req_data[i*DW +: DW]  = base[i] + 32'(cnt[i]);
      req_last[i]           = (cnt[i] == len[i] - 1);
    end
  end

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic int lowest(input logic [NR-1:0] v);
    for (int i = 0; i < NR; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Model: idle picks the lowest requesting index; busy ends on an accepted last beat.
  always @(posedge clk or posedge rst) begin
    if (rst) m_g = -1;
    else if (m_g < 0) m_g = lowest(req_valid);
    else if (req_valid[m_g] && out_ready && req_last[m_g]) m_g = -1;
  end

  // Every-cycle comparison against the model, then record handshakes.
  always @(negedge clk) begin
    logic [NR-1:0] eg, er;
    logic          ev, el;
    logic [DW-1:0] ed;
    logic [1:0]    eid;
    eg = '0; er = '0; ev = 1'b0; el = 1'b0; ed = '0; eid = '0;
    if (m_g >= 0) begin
      eg  = NR'(1) << m_g;
      ev  = req_valid[m_g];
      ed  = req_data[m_g*DW +: DW];
      el  = req_last[m_g];
      eid = 2'(m_g);
      er  = out_ready ? eg : '0;
    end
    check("model_grant", grant, eg);
    check("model_out_valid", out_valid, ev);
    check("model_out_data", out_data, ed);
    check("model_out_last", out_last, el);
    check("model_out_id", out_id, eid);
    check("model_req_ready", req_ready, er);
    fire      = req_valid & req_ready;
    fire_last = req_valid & req_ready & req_last;
  end

  // Advance one clock; requesters react to the handshakes of the finished cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) begin
      if (fire[i]) begin
        if (fire_last[i]) begin
          if (autor[i]) begin cnt[i] = 0; base[i] = base[i] + 32'h1; end
          else act[i] = 1'b0;
        end else cnt[i]++;
      end
    end
    #1;
  endtask

  task automatic start(input int i, input logic [31:0] b, input int l);
    base[i] = b; len[i] = l; cnt[i] = 0; hold[i] = 1'b0; act[i] = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < NR; i++) begin
      act[i] = 0; hold[i] = 0; autor[i] = 0; cnt[i] = 0; len[i] = 1; base[i] = '0;
    end

    // Reset state
    tick();
    check("rst_grant", grant, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_out_id", out_id, 0);
    rst = 1'b0;
    tick();

    // Single requester, three beats
    start(0, 32'hA0, 3);
    check("single_idle_grant", grant, 4'b0000);
    tick(); check("single_grant", grant, 4'b0001); check("single_d0", out_data, 32'hA0); check("single_id", out_id, 0);
    tick(); check("single_d1", out_data, 32'hA1);
    tick(); check("single_d2", out_data, 32'hA2); check("single_last", out_last, 1);
    tick(); check("single_release", grant, 4'b0000);

    // Simultaneous requests 1010
    start(1, 32'hB0, 2);
    start(3, 32'hD0, 2);
    tick(); check("sim_grant1", grant, 4'b0010); check("sim_id1", out_id, 1);
    tick(); check("sim_b1", out_data, 32'hB1);
    tick(); check("sim_idle_gap", grant, 4'b0000);
    tick(); check("sim_grant3", grant, 4'b1000); check("sim_id3", out_id, 3); check("sim_d0", out_data, 32'hD0);
    tick(); check("sim_d1", out_data, 32'hD1);
    tick(); check("sim_release", grant, 4'b0000);

    // Backpressure for four cycles mid-burst
    start(0, 32'hC0, 3);
    tick(); check("bp_grant", grant, 4'b0001);
    tick(); check("bp_c1", out_data, 32'hC1);
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("bp_valid", out_valid, 1);
      check("bp_data", out_data, 32'hC1);
      check("bp_ready", req_ready, 4'b0000);
      check("bp_grant_hold", grant, 4'b0001);
    end
    out_ready = 1'b1;
    tick(); check("bp_c2", out_data, 32'hC2);
    tick(); check("bp_release", grant, 4'b0000);

    // Lock: requester 0 arrives while requester 2 owns the channel
    start(2, 32'hE0, 3);
    tick(); check("lock_grant2", grant, 4'b0100);
    start(0, 32'hF0, 1);
    tick(); check("lock_hold_a", grant, 4'b0100); check("lock_e1", out_data, 32'hE1);
    tick(); check("lock_hold_b", grant, 4'b0100); check("lock_e2", out_data, 32'hE2);
    tick(); check("lock_idle", grant, 4'b0000);
    tick(); check("lock_grant0", grant, 4'b0001); check("lock_f0", out_data, 32'hF0);
    tick(); check("lock_release", grant, 4'b0000);

    // Granted requester drops valid mid-burst: grant held
    start(1, 32'h50, 2);
    tick(); check("drop_grant", grant, 4'b0010);
    hold[1] = 1'b1;
    tick(); check("drop_valid", out_valid, 0); check("drop_grant_hold", grant, 4'b0010);
    tick(); check("drop_grant_hold2", grant, 4'b0010);
    hold[1] = 1'b0;
    tick(); check("drop_resume", out_data, 32'h51);
    tick(); check("drop_release", grant, 4'b0000);

    // Reset during beat 2 of a 4-beat burst
    start(3, 32'h60, 4);
    tick(); check("rb_grant", grant, 4'b1000);
    tick(); check("rb_beat2", out_data, 32'h61);
    rst = 1'b1;
    #1;
    check("rb_grant_drop", grant, 4'b0000);
    check("rb_valid_drop", out_valid, 0);
    check("rb_ready_drop", req_ready, 4'b0000);
    for (int i = 0; i < NR; i++) act[i] = 1'b0;
    tick();
    rst = 1'b0;
    start(0, 32'h11, 1);
    start(3, 32'h33, 1);
    tick(); check("rb_restart", grant, 4'b0001);
    tick(); check("rb_idle", grant, 4'b0000);
    tick(); check("rb_grant3", grant, 4'b1000);
    tick(); check("rb_release", grant, 4'b0000);

    // All four requesting single-beat bursts continuously: fixed priority keeps picking bit 0
    for (int i = 0; i < NR; i++) begin
      autor[i] = 1'b1;
      start(i, 32'h100 * (i + 1), 1);
    end
    for (int k = 0; k < 5; k++) begin
      tick(); check("fp_grant", grant, 4'b0001);
      tick(); check("fp_gap", grant, 4'b0000);
    end
    for (int i = 0; i < NR; i++) begin autor[i] = 1'b0; act[i] = 1'b0; end
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
